reg_bus_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the 8-bit register-access bus (wdata/rdata/addr/direction/enable).
- Accepts single read or write transactions from two masters, e.g. a config sequencer and a debug port.
- Drives one transaction at a time onto the shared bus, with round-robin fairness.
- Captures read data and returns completion per requester.

---
 rtl/reg_bus_arbiter_if.sv | 33 +++
 rtl/reg_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Requester and register-bus signal bundle for reg_bus_arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and bus slave's view.
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              dir0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic              req1;
  logic              dir1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bus_enable;
  logic              bus_direction;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  req0, dir0, addr0, wdata0, req1, dir1, addr1, wdata1, bus_rdata,
    output done0, done1, rsp_rdata, bus_enable, bus_direction, bus_addr, bus_wdata
  );

  modport slave (
    output req0, dir0, addr0, wdata0, req1, dir1, addr1, wdata1, bus_rdata,
    input  done0, done1, rsp_rdata, bus_enable, bus_direction, bus_addr, bus_wdata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the 8-bit register bus.
// Optional grant counters are enabled by defining REG_BUS_ARB_STATS_EN.
module reg_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  reg_bus_arbiter_if.master  rb
`ifdef REG_BUS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   gnt_cnt0,
  output logic [CNT_W-1:0]   gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, DONE} state_t;

  state_t            state_r;
  logic              last_grant_r;
  logic              gnt_id_r;
  logic              bus_enable_r;
  logic              bus_dir_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              done0_r;
  logic              done1_r;

  logic              grant_s;
  logic              pick_s;
  logic              win_dir_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  // Round-robin winner selection and mux of the winner's request fields
  always_comb begin
    grant_s = rb.req0 | rb.req1;
    if (rb.req0 && rb.req1) begin
      pick_s = ~last_grant_r;
    end else if (rb.req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      win_dir_s   = rb.dir1;
      win_addr_s  = rb.addr1;
      win_wdata_s = rb.wdata1;
    end else begin
      win_dir_s   = rb.dir0;
      win_addr_s  = rb.addr0;
      win_wdata_s = rb.wdata0;
    end
  end

  // Transaction sequencer; done is raised on entry to DONE so it is high exactly in that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      gnt_id_r     <= 1'b0;
      bus_enable_r <= 1'b0;
      bus_dir_r    <= 1'b0;
      bus_addr_r   <= '0;
      bus_wdata_r  <= '0;
      rsp_rdata_r  <= '0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
    end else begin
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            bus_enable_r <= 1'b1;
            bus_dir_r    <= win_dir_s;
            bus_addr_r   <= win_addr_s;
            bus_wdata_r  <= win_wdata_s;
            gnt_id_r     <= pick_s;
            last_grant_r <= pick_s;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          bus_enable_r <= 1'b0;
          if (bus_dir_r) begin
            done0_r <= ~gnt_id_r;
            done1_r <= gnt_id_r;
            state_r <= DONE;
          end else begin
            state_r <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rsp_rdata_r <= rb.bus_rdata;
          done0_r     <= ~gnt_id_r;
          done1_r     <= gnt_id_r;
          state_r     <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          bus_enable_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign rb.bus_enable    = bus_enable_r;
  assign rb.bus_direction = bus_dir_r;
  assign rb.bus_addr      = bus_addr_r;
  assign rb.bus_wdata     = bus_wdata_r;
  assign rb.rsp_rdata     = rsp_rdata_r;
  assign rb.done0         = done0_r;
  assign rb.done1         = done1_r;

`ifdef REG_BUS_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] gnt_cnt0_r;
  logic [CNT_W-1:0] gnt_cnt1_r;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_r <= '0;
      gnt_cnt1_r <= '0;
    end else if ((state_r == IDLE) && grant_s) begin
      if (!pick_s && (gnt_cnt0_r != CNT_MAX)) begin
        gnt_cnt0_r <= gnt_cnt0_r + CNT_ONE;
      end else if (pick_s && (gnt_cnt1_r != CNT_MAX)) begin
        gnt_cnt1_r <= gnt_cnt1_r + CNT_ONE;
      end else begin
        gnt_cnt0_r <= gnt_cnt0_r;
      end
    end else begin
      gnt_cnt0_r <= gnt_cnt0_r;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_r;
  assign gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed self-checking bench for reg_bus_arbiter with a small register-slave model.
// Grant-counter checks are compiled in when REG_BUS_ARB_STATS_EN is defined.
module tb_reg_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.ADDR_W(32), .DATA_W(8)) rb ();

`ifdef REG_BUS_ARB_STATS_EN
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;
  logic [1:0]  sat_cnt0;
  logic [1:0]  sat_cnt1;
  reg_bus_arbiter_if #(.ADDR_W(32), .DATA_W(8)) rb_sat ();
  assign rb_sat.req0      = rb.req0;
  assign rb_sat.dir0      = rb.dir0;
  assign rb_sat.addr0     = rb.addr0;
  assign rb_sat.wdata0    = rb.wdata0;
  assign rb_sat.req1      = rb.req1;
  assign rb_sat.dir1      = rb.dir1;
  assign rb_sat.addr1     = rb.addr1;
  assign rb_sat.wdata1    = rb.wdata1;
  assign rb_sat.bus_rdata = rb.bus_rdata;

  reg_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rb(rb_sat), .gnt_cnt0(sat_cnt0), .gnt_cnt1(sat_cnt1)
  );
`endif

  reg_bus_arbiter #(.ADDR_W(32), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rb(rb)
`ifdef REG_BUS_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // Register slave: address 0 is a status register (bit0 = any write seen, bit4 = any read seen)
  logic [7:0] mem [0:255];
  logic [7:0] status_r    = 8'h00;
  logic [7:0] slave_rdata = 8'h00;
  assign rb.bus_rdata = slave_rdata;

  always @(posedge clk) begin
    if (rb.bus_enable) begin
      if (rb.bus_direction) begin
        mem[rb.bus_addr[7:0]] <= rb.bus_wdata;
        status_r[0]           <= 1'b1;
      end else begin
        slave_rdata <= (rb.bus_addr[7:0] == 8'h00) ? status_r : mem[rb.bus_addr[7:0]];
        status_r[4] <= 1'b1;
      end
    end
  end

  task automatic idle_reqs();
    rb.req0 = 1'b0; rb.dir0 = 1'b0; rb.addr0 = 32'h0; rb.wdata0 = 8'h00;
    rb.req1 = 1'b0; rb.dir1 = 1'b0; rb.addr1 = 32'h0; rb.wdata1 = 8'h00;
  endtask

  task automatic test_reset();
    idle_reqs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rb.bus_enable !== 1'b0) begin errors++; $display("FAIL reset_bus_enable got=%0h exp=0", rb.bus_enable); end
    checks++; if (rb.bus_direction !== 1'b0) begin errors++; $display("FAIL reset_bus_direction got=%0h exp=0", rb.bus_direction); end
    checks++; if (rb.bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got=%0h exp=0", rb.bus_addr); end
    checks++; if (rb.bus_wdata !== 8'h00) begin errors++; $display("FAIL reset_bus_wdata got=%0h exp=0", rb.bus_wdata); end
    checks++; if ({rb.done0, rb.done1} !== 2'b00) begin errors++; $display("FAIL reset_done got=%0b exp=00", {rb.done0, rb.done1}); end
    checks++; if (rb.rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp_rdata got=%0h exp=0", rb.rsp_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rb.bus_enable !== 1'b0) begin errors++; $display("FAIL idle_no_req_enable got=%0h exp=0", rb.bus_enable); end
  endtask

  task automatic test_single_write();
    rb.req0 = 1'b1; rb.dir0 = 1'b1; rb.addr0 = 32'h1; rb.wdata0 = 8'hA5;
    @(negedge clk);
    checks++; if (rb.bus_enable !== 1'b1) begin errors++; $display("FAIL wr_enable got=%0h exp=1", rb.bus_enable); end
    checks++; if (rb.bus_direction !== 1'b1) begin errors++; $display("FAIL wr_direction got=%0h exp=1", rb.bus_direction); end
    checks++; if (rb.bus_addr !== 32'h1) begin errors++; $display("FAIL wr_addr got=%0h exp=1", rb.bus_addr); end
    checks++; if (rb.bus_wdata !== 8'hA5) begin errors++; $display("FAIL wr_wdata got=%0h exp=a5", rb.bus_wdata); end
    checks++; if (rb.done0 !== 1'b0) begin errors++; $display("FAIL wr_done_early got=%0h exp=0", rb.done0); end
    @(negedge clk);
    checks++; if ({rb.done0, rb.done1} !== 2'b10) begin errors++; $display("FAIL wr_done got=%0b exp=10", {rb.done0, rb.done1}); end
    checks++; if (rb.bus_enable !== 1'b0) begin errors++; $display("FAIL wr_enable_one_cycle got=%0h exp=0", rb.bus_enable); end
    checks++; if (rb.rsp_rdata !== 8'h00) begin errors++; $display("FAIL wr_rsp_unchanged got=%0h exp=0", rb.rsp_rdata); end
    rb.req0 = 1'b0;
    @(negedge clk);
    checks++; if (rb.done0 !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got=%0h exp=0", rb.done0); end
    checks++; if (rb.bus_addr !== 32'h1) begin errors++; $display("FAIL wr_addr_hold got=%0h exp=1", rb.bus_addr); end
  endtask

  task automatic test_single_read();
    rb.req1 = 1'b1; rb.dir1 = 1'b0; rb.addr1 = 32'h1;
    @(negedge clk);
    checks++; if ({rb.bus_enable, rb.bus_direction} !== 2'b10) begin errors++; $display("FAIL rd_strobe got=%0b exp=10", {rb.bus_enable, rb.bus_direction}); end
    @(negedge clk);
    checks++; if ({rb.bus_enable, rb.done1} !== 2'b00) begin errors++; $display("FAIL rd_wait got=%0b exp=00", {rb.bus_enable, rb.done1}); end
    @(negedge clk);
    checks++; if ({rb.done0, rb.done1} !== 2'b01) begin errors++; $display("FAIL rd_done got=%0b exp=01", {rb.done0, rb.done1}); end
    checks++; if (rb.rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_rdata got=%0h exp=a5", rb.rsp_rdata); end
    rb.req1 = 1'b0;
    @(negedge clk);
    checks++; if (rb.done1 !== 1'b0) begin errors++; $display("FAIL rd_done_pulse got=%0h exp=0", rb.done1); end
  endtask

  task automatic test_status_read();
    rb.req0 = 1'b1; rb.dir0 = 1'b0; rb.addr0 = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (rb.done0 !== 1'b1) begin errors++; $display("FAIL status_done got=%0h exp=1", rb.done0); end
    checks++; if (rb.rsp_rdata !== 8'h11) begin errors++; $display("FAIL status_rdata got=%0h exp=11", rb.rsp_rdata); end
    rb.dir0 = 1'b1; rb.addr0 = 32'h3; rb.wdata0 = 8'h5A;
    repeat (3) @(negedge clk);
    checks++; if (rb.done0 !== 1'b1) begin errors++; $display("FAIL wr2_done got=%0h exp=1", rb.done0); end
    checks++; if (rb.rsp_rdata !== 8'h11) begin errors++; $display("FAIL wr_keeps_rsp got=%0h exp=11", rb.rsp_rdata); end
    rb.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    rb.req0 = 1'b1; rb.dir0 = 1'b0; rb.addr0 = 32'h1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rb.rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_rsp got=%0h exp=0", rb.rsp_rdata); end
    checks++; if (rb.bus_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_enable got=%0h exp=0", rb.bus_enable); end
    rb.req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({rb.done0, rb.done1} !== 2'b00) begin errors++; $display("FAIL rst_mid_no_done cyc=%0d got=%0b exp=00", i, {rb.done0, rb.done1}); end
    end
    rst_n = 1'b1;
    rb.req0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({rb.done0, rb.rsp_rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rst_after_read got=%0h exp=1a5", {rb.done0, rb.rsp_rdata}); end
    rb.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [7:0] exp_wd;
    logic [1:0] exp_done;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rb.req0 = 1'b1; rb.dir0 = 1'b1; rb.addr0 = 32'h2; rb.wdata0 = 8'h11;
    rb.req1 = 1'b1; rb.dir1 = 1'b1; rb.addr1 = 32'h2; rb.wdata1 = 8'h22;
    for (int g = 0; g < 4; g++) begin
      exp_wd   = (g % 2 == 0) ? 8'h11 : 8'h22;
      exp_done = (g % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++; if ({rb.bus_enable, rb.bus_wdata} !== {1'b1, exp_wd}) begin errors++; $display("FAIL cont_issue g=%0d got=%0h exp=%0h", g, {rb.bus_enable, rb.bus_wdata}, {1'b1, exp_wd}); end
      @(negedge clk);
      checks++; if ({rb.done0, rb.done1} !== exp_done) begin errors++; $display("FAIL cont_done g=%0d got=%0b exp=%0b", g, {rb.done0, rb.done1}, exp_done); end
      if (g == 3) begin
        rb.req0 = 1'b0;
        rb.req1 = 1'b0;
      end
      @(negedge clk);
      checks++; if ({rb.bus_enable, rb.done0, rb.done1} !== 3'b000) begin errors++; $display("FAIL cont_idle g=%0d got=%0b exp=000", g, {rb.bus_enable, rb.done0, rb.done1}); end
    end
  endtask

`ifdef REG_BUS_ARB_STATS_EN
  task automatic do_write(input bit id);
    int n;
    n = 0;
    if (id) begin rb.req1 = 1'b1; rb.dir1 = 1'b1; rb.addr1 = 32'h4; end
    else    begin rb.req0 = 1'b1; rb.dir0 = 1'b1; rb.addr0 = 32'h4; end
    @(negedge clk);
    while (((id ? rb.done1 : rb.done0) !== 1'b1) && (n < 8)) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 8) begin errors++; $display("FAIL stats_wait id=%0d got=timeout exp=done", id); end
    rb.req0 = 1'b0;
    rb.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stats();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) do_write(1'b0);
    for (int i = 0; i < 3; i++) do_write(1'b1);
    checks++; if (gnt_cnt0 !== 16'd5) begin errors++; $display("FAIL stats_cnt0 got=%0d exp=5", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 16'd3) begin errors++; $display("FAIL stats_cnt1 got=%0d exp=3", gnt_cnt1); end
    checks++; if (sat_cnt0 !== 2'd3) begin errors++; $display("FAIL stats_sat0 got=%0d exp=3", sat_cnt0); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_status_read();
    test_reset_mid_read();
    test_contention();
`ifdef REG_BUS_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
